gray_codec: RTL
===============

GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001: Parameter WIDTH, default 4, code word width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset; synchronous and active-high.
REQ-004: in_valid  input  1  upstream word present.
REQ-005: in_ready  output  1  block accepts input this cycle.
REQ-006: in_mode  input  2  operation: 00 BIN2GRAY, 01 GRAY2BIN, 10 GRAY_INC, 11 PASS.
REQ-007: in_data  input  WIDTH  operand word.
REQ-008: out_valid  output  1  result word held in output register.
REQ-009: out_ready  input  1  downstream accepts result this cycle.
REQ-010: out_mode  output  2  mode that produced out_data.
REQ-011: out_data  output  WIDTH  result word.
REQ-012: out_wrap  output  1  high with a GRAY_INC result whose binary value wrapped from all-ones to zero; otherwise low.

Function
REQ-013: Input handshake fires when in_valid && in_ready; output handshake fires when out_valid && out_ready.
REQ-014: in_ready SHALL equal !out_valid || out_ready, combinationally; this gives full throughput of one word per cycle under no backpressure.
REQ-015: Latency SHALL be exactly 1 cycle: a word accepted at edge N appears with out_valid high after edge N.
REQ-016: BIN2GRAY: out[i] = in[i] ^ in[i+1] for i < WIDTH-1; out[WIDTH-1] = in[WIDTH-1].
REQ-017: GRAY2BIN: out[WIDTH-1] = in[WIDTH-1]; out[i] = out[i+1] ^ in[i] (prefix XOR from MSB).
REQ-018: GRAY_INC: convert to binary, add 1 modulo 2^WIDTH, convert back to Gray; out_wrap = 1 iff the binary operand is all-ones.
REQ-019: PASS: out_data = in_data.
REQ-020: The output register (out_valid, out_data, out_mode, out_wrap) SHALL load on an input handshake.
REQ-021: Without an input handshake, the register SHALL hold while out_valid && !out_ready, and out_data, out_mode and out_wrap SHALL remain stable.
REQ-022: An output handshake with no simultaneous input handshake SHALL clear out_valid at the next edge.
REQ-023: Simultaneous input and output handshakes SHALL replace the register contents with the new result; out_valid stays high.
REQ-024: in_data and in_mode SHALL be ignored when in_valid is low, and SHALL not affect any output.

Reset
REQ-025: While rst is high at a rising edge: out_valid, out_data, out_mode and out_wrap SHALL all be 0.
REQ-026: rst SHALL take priority over any handshake in the same cycle; a word held or being accepted is discarded.
REQ-027: in_ready SHALL be 1 during and immediately after reset, because out_valid is 0.

Structure
REQ-028: Package gray_pkg SHALL hold the mode enum (BIN2GRAY, GRAY2BIN, GRAY_INC, PASS) and the mode width constant.
REQ-029: One combinational sub-module, gray_core, SHALL compute the result from WIDTH, mode and data; gray_codec adds only the handshake and the output register.

Verification (WIDTH=4)
REQ-030: rst high 2 cycles, then low -> out_valid=0, out_data=0000, in_ready=1.
REQ-031: BIN2GRAY 0101, then GRAY2BIN 0111, on back-to-back cycles with out_ready=1 -> outputs 0111, then 0101, on consecutive cycles.
REQ-032: GRAY_INC 1000 (binary 15) -> out_data=0000, out_wrap=1; GRAY_INC 0000 -> 0001, out_wrap=0.
REQ-033: out_ready=0 for 3 cycles with in_valid high -> in_ready=0 and out_data held stable; out_ready then 1 -> the held word transfers and the next word loads on the same edge.
REQ-034: rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and the held word is never delivered.
REQ-035: Exhaustive sweep of all 16 values in all 4 modes -> results match the REQ-016..019 formulas; GRAY2BIN(BIN2GRAY(x)) = x for every x.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared mode encoding and widths for the Gray-code codec.
package gray_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BIN2GRAY = 2'b00,
    GRAY2BIN = 2'b01,
    GRAY_INC = 2'b10,
    PASS     = 2'b11
  } mode_e;

endpackage

// File: rtl/gray_core.sv
// Combinational Gray-code datapath: convert, increment-in-Gray, or pass-through.
// Zero latency, no state; wrap flags a GRAY_INC whose binary operand was all-ones.
module gray_core
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_wrap
);

  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_inc_bin;
  logic [WIDTH-1:0] w_inc_gray;
  logic             w_all_ones;

  assign w_b2g = i_data ^ (i_data >> 1);

  // Binary bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    w_g2b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_g2b[i] = ^(i_data >> i);
    end
  end

  assign w_all_ones = &w_g2b;
  assign w_inc_bin  = w_g2b + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_inc_gray = w_inc_bin ^ (w_inc_bin >> 1);

  always_comb begin
    o_data = i_data;
    o_wrap = 1'b0;
    case (i_mode)
      BIN2GRAY: o_data = w_b2g;
      GRAY2BIN: o_data = w_g2b;
      GRAY_INC: begin
        o_data = w_inc_gray;
        o_wrap = w_all_ones;
      end
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/gray_codec.sv
// Gray-code codec with one registered output stage; latency 1 cycle, full throughput.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds stable.
module gray_codec
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MODE_W-1:0] out_mode,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_wrap
);

  logic              r_valid;
  logic [MODE_W-1:0] r_mode;
  logic [WIDTH-1:0]  r_data;
  logic              r_wrap;

  logic [WIDTH-1:0]  w_res;
  logic              w_wrap;
  logic              w_in_hs;
  logic              w_out_hs;

  gray_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_mode (in_mode),
    .i_data (in_data),
    .o_data (w_res),
    .o_wrap (w_wrap)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_valid && out_ready;

  // Reset wins over any handshake, so a held or incoming word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_mode  <= '0;
      r_data  <= '0;
      r_wrap  <= 1'b0;
    end else if (w_in_hs) begin
      r_valid <= 1'b1;
      r_mode  <= in_mode;
      r_data  <= w_res;
      r_wrap  <= w_wrap;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_mode  = r_mode;
  assign out_data  = r_data;
  assign out_wrap  = r_wrap;

endmodule
